// File: rtl/key_entry_pkg.sv
// Shared definitions for the key entry controller: press codes, FSM state
// encoding and the largest legal digit value.
package key_entry_pkg;

  localparam logic [2:0] PRESS_NEXT    = 3'd0;
  localparam logic [2:0] PRESS_BACK    = 3'd1;
  localparam logic [2:0] PRESS_CONFIRM = 3'd2;
  localparam logic [2:0] PRESS_DELETE  = 3'd3;
  localparam logic [2:0] PRESS_HOME    = 3'd4;
  localparam logic [2:0] PRESS_NONE    = 3'd7;

  localparam int unsigned DIGIT_MAX = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ENTRY  = 2'b01,
    ST_SUBMIT = 2'b10
  } state_e;

endpackage

// File: rtl/entry_timeout_timer.sv
// Inactivity timer for an entry session.
// Ports: clk, rst_n (async, active-low); run enables counting; restart clears
// the count; expire is high during the cycle the count sits at TIMEOUT_CYC-1.
module entry_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = run && (cnt == LAST);

  // Counter is held at zero outside a session, so entering ENTRY starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || restart || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_entry_controller.sv
// Multi-digit key entry session controller.
// Ports: clk, rst_n (async, active-low); press (3-bit code, 7 = none);
// sub_ready (downstream accept); state, cur_digit, entry_count, entry_buf
// (slot 0 in LSBs); sub_valid (high in SUBMIT); done / err one-cycle pulses.
module key_entry_controller
  import key_entry_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 press,
  input  logic                       sub_ready,
  output logic [1:0]                 state,
  output logic [DIGIT_W-1:0]         cur_digit,
  output logic [3:0]                 entry_count,
  output logic [MAX_LEN*DIGIT_W-1:0] entry_buf,
  output logic                       sub_valid,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned BUF_W = MAX_LEN * DIGIT_W;

  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] cur_q, cur_d;
  logic [3:0]         count_q, count_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               press_valid;
  logic               expire;

  assign press_valid = (press <= PRESS_HOME);

  entry_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state_q == ST_ENTRY),
    .restart (press_valid),
    .expire  (expire)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    count_d = count_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (press == PRESS_CONFIRM) begin
          state_d = ST_ENTRY;
          cur_d   = '0;
          count_d = '0;
          buf_d   = '0;
        end
      end

      ST_ENTRY: begin
        case (press)
          PRESS_NEXT: begin
            cur_d = (cur_q == DIGIT_W'(DIGIT_MAX)) ? '0 : cur_q + DIGIT_W'(1);
          end
          PRESS_BACK: begin
            if (count_q == 4'd0) state_d = ST_IDLE;
            else                 cur_d   = '0;
          end
          PRESS_CONFIRM: begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              if (count_q == 4'(i)) buf_d[i*DIGIT_W +: DIGIT_W] = cur_q;
            end
            count_d = count_q + 4'd1;
            cur_d   = '0;
            if (count_d == 4'(MAX_LEN)) state_d = ST_SUBMIT;
          end
          PRESS_DELETE: begin
            if (count_q == 4'd0) begin
              err_d = 1'b1;
            end else begin
              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (count_q == 4'(i + 1)) buf_d[i*DIGIT_W +: DIGIT_W] = '0;
              end
              count_d = count_q - 4'd1;
              cur_d   = '0;
            end
          end
          PRESS_HOME: begin
            state_d = ST_IDLE;
            cur_d   = '0;
            count_d = '0;
            buf_d   = '0;
          end
          PRESS_NONE: ;
          default: err_d = 1'b1;   // invalid codes 101/110
        endcase

        // A valid press in the expiry cycle takes precedence over the timeout.
        if (!press_valid && expire) begin
          state_d = ST_IDLE;
          cur_d   = '0;
          count_d = '0;
          buf_d   = '0;
          err_d   = 1'b1;
        end
      end

      ST_SUBMIT: begin
        if (sub_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cur_d   = '0;
          count_d = '0;
          buf_d   = '0;
        end else if (press == PRESS_HOME) begin
          state_d = ST_IDLE;
          cur_d   = '0;
          count_d = '0;
          buf_d   = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign state       = state_q;
  assign cur_digit   = cur_q;
  assign entry_count = count_q;
  assign entry_buf   = buf_q;
  assign sub_valid   = (state_q == ST_SUBMIT);
  assign err         = err_q;
  assign done        = done_q;

endmodule

// File: doc/key_entry_controller.md
Name: key_entry_controller

Overview:
- Consumes the one-cycle press codes from the debounced button encoder.
- Sequences a multi-digit entry session: digit selection, append, delete, abort and inactivity timeout.
- Presents the completed digit string to the downstream game/lock logic over a valid/ready handshake.
- Sits between the button encoder and the application FSMs, and is the only consumer of the press codes.

Parameters:
- MAX_LEN, 4: digits per entry; range 1..8.
- DIGIT_W, 4: bits per digit. Digit values are 0..9.
- TIMEOUT_CYC, 500_000_000: inactivity limit in clk cycles while in ENTRY. Bench uses 20.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- press  in  3  press code. 3'b111 means no press. 000..100 are one-cycle events. 101 and 110 are invalid.
- sub_ready  in  1  downstream accepts the submitted entry.
- state  out  2  00 IDLE, 01 ENTRY, 10 SUBMIT.
- cur_digit  out  DIGIT_W  digit currently being selected.
- entry_count  out  4  digits stored so far (0..MAX_LEN).
- entry_buf  out  MAX_LEN*DIGIT_W  stored digits; slot 0 is in the LSBs.
- sub_valid  out  1  entry complete; held high until accepted.
- done  out  1  one-cycle pulse on handshake completion.
- err  out  1  one-cycle pulse on error event.

Behaviour:
- Reset: every output and internal register is 0, and state is IDLE. Reset mid-operation aborts immediately with no handshake.
- Press events are registered. All effects are visible on the cycle after the press code appears; there is no other latency.
- Code meanings:
  - 0: NEXT
  - 1: BACK
  - 2: CONFIRM
  - 3: DELETE
  - 4: HOME
- IDLE:
  - CONFIRM goes to ENTRY with cur_digit=0, count=0, buf=0, and the timer cleared.
  - All other codes are ignored. No err.
- ENTRY:
  - NEXT: cur_digit increments; 9 wraps to 0.
  - CONFIRM: buf[count]<=cur_digit, count++, cur_digit<=0. If the new count equals MAX_LEN, go to SUBMIT.
  - DELETE with count>0: count--, buf[count-1]<=0, cur_digit<=0.
  - DELETE with count==0: no change, err pulse.
  - BACK with count==0: go to IDLE.
  - BACK with count>0: cur_digit<=0 only.
  - HOME: go to IDLE and clear buf, count and cur_digit.
  - Codes 101 and 110: err pulse, no other effect, and the timer is not reset.
- Timeout:
  - The counter runs only in ENTRY. It resets on entering ENTRY and on every valid code (000..100).
  - When the counter reaches TIMEOUT_CYC-1 with no press that cycle: go to IDLE, clear everything, err pulse.
  - If a press and the timeout expire in the same cycle, the press wins and the counter resets.
- SUBMIT:
  - sub_valid=1 combinationally from state. entry_buf and entry_count are frozen.
  - On sub_valid && sub_ready: done pulse, go to IDLE, clear buf, count and cur_digit.
  - HOME aborts to IDLE and clears everything, with no done pulse. This is the only case where valid drops without ready.
  - If HOME and sub_ready arrive in the same cycle, the handshake wins: done pulses.
  - Codes 0 to 3 are ignored.
- err and done are never high in the same cycle.
- entry_count width is fixed at 4 bits. Arithmetic never wraps: the count is bounded 0..MAX_LEN by the rules above.

Decomposition:
- Shared package key_entry_pkg:
  - press code localparams: PRESS_NEXT=0, PRESS_BACK=1, PRESS_CONFIRM=2, PRESS_DELETE=3, PRESS_HOME=4, PRESS_NONE=7.
  - state encodings.
  - DIGIT_MAX=9.
- Sub-module entry_timeout_timer:
  - inputs: clk, rst_n, run, restart.
  - output: expire pulse.
  - parameter: TIMEOUT_CYC.
- The main module holds the FSM, buffer and handshake.

Test Plan:
- Basic entry: reset; CONFIRM; then enter digits 3,0,7,1 using NEXT presses and CONFIRM. Required: state=SUBMIT, entry_buf=16'h1703, sub_valid=1. Then sub_ready=1 for 1 cycle. Required: done pulse, state=IDLE, buf=0.
- Wrap and delete: in ENTRY, 11 NEXT presses give cur_digit=1. CONFIRM gives count=1. DELETE gives count=0 and buf=0. A second DELETE gives an err pulse with count still 0.
- Timeout (TIMEOUT_CYC=20): CONFIRM into ENTRY, CONFIRM one digit, then idle 20 cycles. Required: err pulse on the 20th cycle, state=IDLE, count=0. A repeat with a NEXT press on cycle 19 gives no timeout, and the counter restarts.
- Backpressure: reach SUBMIT with sub_ready=0 held for 10 cycles while pressing NEXT and DELETE. Required: sub_valid stays 1 and buf is unchanged. Then HOME and sub_ready in the same cycle. Required: done pulses.
- Abort and reset: HOME in SUBMIT gives IDLE, sub_valid=0, no done. rst_n asserted mid-ENTRY with count=2 gives all outputs 0 immediately (asynchronously).
- Invalid codes: press=101 in ENTRY gives an err pulse with no state change and no timer reset. press=101 in IDLE gives no err.
